data_io_master: RTL
===================

DATA_IO_MASTER -- requirements
Module: data_io_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, setting the sck half-period in clk cycles (legal range 2..255).
REQ-002 The block SHALL have parameter SS_GAP, default 8, setting the minimum clk cycles ss stays high between transactions.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1), cmd (input, 8), arg (input, 32) and len (input, 10): the command request handshake, where len is the word or byte count.
REQ-006 The block SHALL have ports wr_req (output, 1), wr_valid (input, 1) and wr_data (input, 16): the write-word request and its data.
REQ-007 The block SHALL have ports rd_valid (output, 1) and rd_data (output, 16): a one-cycle strobe with the read word.
REQ-008 The block SHALL have ports st_valid (output, 1), st_data (output, 8) and st_index (output, 5): a one-cycle strobe with a status byte and its byte position.
REQ-009 The block SHALL have port abort, input, 1 bit: request to end the current transaction early (see Configuration).
REQ-010 The block SHALL have ports sck (output, 1), ss (output, 1), sdi (output, 1) and sdo (input, 1): the SPI master pins.
REQ-011 The block SHALL have port busy, output, 1 bit: high from command acceptance until the SS_GAP period ends.

Function
REQ-012 The block SHALL accept a command when cmd_valid and cmd_ready are both high, latching cmd, arg and len; cmd_ready SHALL be high only in IDLE.
REQ-013 The state machine SHALL use states IDLE, SETUP, SHIFT, WAIT_WR, HOLD and GAP. Transitions:
- IDLE to SETUP on accept.
- SETUP to SHIFT after CLK_DIV cycles.
- SHIFT to WAIT_WR when the next byte is a write high byte and no word is held.
- SHIFT to HOLD after the last byte.
- HOLD to GAP after CLK_DIV cycles.
- GAP to IDLE after SS_GAP cycles.
REQ-014 ss SHALL go low on entry to SETUP and return high on entry to GAP.
REQ-015 Each bit SHALL be transmitted with sck low for CLK_DIV cycles and then high for CLK_DIV cycles.
REQ-016 sdi SHALL change only while sck is low, at the start of the low phase; bits SHALL be sent MSB first.
REQ-017 sdo SHALL be sampled in the clk cycle in which sck rises.
REQ-018 Byte 0 of every transaction SHALL be the cmd byte. The payload that follows SHALL be:
- 0x01 and 0x04: arg[31:24], arg[23:16], arg[15:8], arg[7:0].
- 0x09: arg[15:8], arg[7:0].
- 0x06: arg[7:0].
- 0x02: len words, each sent high byte then low byte.
- 0x03: 2*len bytes, sdi=0.
- 0x05: len bytes (max 31), sdi=0.
- Any other code: no payload.
REQ-019 For cmd 0x02, wr_req SHALL pulse for one cycle once per word, before that word's high byte.
REQ-020 For cmd 0x02, the block SHALL wait in WAIT_WR, with sck low and ss low, until wr_valid is high, and SHALL then latch wr_data.
REQ-021 For cmd 0x03, rd_valid SHALL pulse one cycle after the last rising sck of each byte pair, with rd_data = {first byte received, second byte received}.
REQ-022 For cmd 0x05, st_valid SHALL pulse after each payload byte, with st_index running 1..len and st_data holding the received byte.
REQ-023 When len=0 for cmd 0x02, 0x03 or 0x05, only the cmd byte SHALL be sent, and no wr_req, rd_valid or st_valid SHALL be produced.
REQ-024 A transaction of N bytes SHALL hold ss low for exactly CLK_DIV*(2+2*8*N) cycles, plus any WAIT_WR cycles.
REQ-025 cmd_valid SHALL be ignored while busy is high; inputs arriving in the same cycle the block returns to IDLE SHALL be accepted in the next cycle.

Reset
REQ-026 While reset_n is low, the block SHALL drive sck=0, ss=1, sdi=0, cmd_ready=0, busy=0, wr_req=0, rd_valid=0, st_valid=0, rd_data=0, st_data=0 and st_index=0, and the state SHALL be IDLE.
REQ-027 A reset asserted mid-transaction SHALL raise ss asynchronously, and no partial-word strobe SHALL follow.
REQ-028 cmd_ready SHALL rise on the first clk edge after reset_n deasserts.

Configuration
REQ-029 With DATA_IO_MASTER_ABORT_EN defined, abort=1 SHALL cause the block to finish the current byte, then enter HOLD and GAP; remaining bytes SHALL be skipped, and no strobe SHALL be issued for an incomplete word.
REQ-030 With DATA_IO_MASTER_ABORT_EN undefined, the abort port SHALL be ignored.

Verification
REQ-031 Bench: CLK_DIV=2, cmd 0x01 with arg 0x0A812345 -> sdi bytes 01 0A 81 23 45, 40 rising sck edges, ss low for 164 cycles.
REQ-032 Bench: cmd 0x02, len=2, words 0xBEEF and 0x1234 -> bytes 02 BE EF 12 34 and exactly 2 wr_req pulses.
REQ-033 Bench: cmd 0x03, len=1, slave model drives 0xA55A -> one rd_valid pulse with rd_data=0xA55A.
REQ-034 Bench: cmd 0x02 with wr_valid delayed 20 cycles -> sck held low and ss held low, then the correct bytes are sent.
REQ-035 Bench: cmd 0x05, len=3, slave returns 11 22 33 -> st_index values 1, 2, 3 with matching st_data.
REQ-036 Bench: reset_n pulled low during byte 2 -> ss=1 within the same cycle, no strobes, then cmd_ready=1 after reset_n deasserts.

Source files
------------

// File: rtl/data_io_master.sv
// data_io_master: SPI master that frames a command byte plus a command-specific
// payload (argument bytes, streamed write words, read words or status bytes).
// Optional feature: define DATA_IO_MASTER_ABORT_EN to honour the abort input.
module data_io_master #(
   parameter int CLK_DIV = 4,
   parameter int SS_GAP  = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd,
   input  logic [31:0] arg,
   input  logic [9:0]  len,
   output logic        wr_req,
   input  logic        wr_valid,
   input  logic [15:0] wr_data,
   output logic        rd_valid,
   output logic [15:0] rd_data,
   output logic        st_valid,
   output logic [7:0]  st_data,
   output logic [4:0]  st_index,
   input  logic        abort,
   output logic        sck,
   output logic        ss,
   output logic        sdi,
   input  logic        sdo,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT_WR, HOLD, GAP} state_t;

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LAST = 16'(SS_GAP - 1);

   state_t      state;
   logic [15:0] cnt;
   logic [2:0]  bit_cnt;
   logic [11:0] byte_idx;
   logic [11:0] nbytes;
   logic [7:0]  cmd_q;
   logic [7:0]  tx;
   logic [7:0]  rx;
   logic [7:0]  rd_first;
   logic [7:0]  word_lo;
   logic [31:0] pay;
   logic        rx_done;
   logic        stop_early;
   logic        last_byte;
   logic [7:0]  next_byte;

   // Total frame length in bytes, command byte included
   function automatic logic [11:0] byte_total(input logic [7:0] c, input logic [9:0] l);
      case (c)
         8'h01, 8'h04: return 12'd5;
         8'h09:        return 12'd3;
         8'h06:        return 12'd2;
         8'h02, 8'h03: return 12'd1 + {1'b0, l, 1'b0};
         8'h05:        return (l > 10'd31) ? 12'd32 : 12'd1 + {2'b00, l};
         default:      return 12'd1;
      endcase
   endfunction

   // Argument bytes left-aligned so the payload always leaves from bits 31:24
   function automatic logic [31:0] arg_bytes(input logic [7:0] c, input logic [31:0] a);
      case (c)
         8'h01, 8'h04: return a;
         8'h09:        return {a[15:0], 16'h0000};
         8'h06:        return {a[7:0], 24'h000000};
         default:      return '0;
      endcase
   endfunction

`ifdef DATA_IO_MASTER_ABORT_EN
   logic abort_req;

   // Remember an abort until the current byte finishes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         abort_req <= 1'b0;
      else if (state == IDLE)
         abort_req <= 1'b0;
      else if (abort && (state == SETUP || state == SHIFT || state == WAIT_WR))
         abort_req <= 1'b1;
   end

   assign stop_early = abort_req | abort;
`else
   logic unused_abort;
   assign unused_abort = abort;
   assign stop_early   = 1'b0;
`endif

   assign last_byte = (byte_idx + 12'd1 == nbytes);
   assign next_byte = (cmd_q == 8'h02) ? word_lo : pay[31:24];

   // Transaction sequencer, bit engine and registered strobes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         byte_idx  <= '0;
         nbytes    <= '0;
         cmd_q     <= '0;
         tx        <= '0;
         rx        <= '0;
         rd_first  <= '0;
         word_lo   <= '0;
         pay       <= '0;
         rx_done   <= 1'b0;
         cmd_ready <= 1'b0;
         busy      <= 1'b0;
         wr_req    <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         st_valid  <= 1'b0;
         st_data   <= '0;
         st_index  <= '0;
         sck       <= 1'b0;
         ss        <= 1'b1;
         sdi       <= 1'b0;
      end else begin
         wr_req   <= 1'b0;
         rd_valid <= 1'b0;
         st_valid <= 1'b0;
         rx_done  <= 1'b0;

         // rx_done fires the cycle after the last rising sck of a byte
         if (rx_done && byte_idx != 12'd0) begin
            if (cmd_q == 8'h03) begin
               if (byte_idx[0]) begin
                  rd_first <= rx;
               end else begin
                  rd_valid <= 1'b1;
                  rd_data  <= {rd_first, rx};
               end
            end else if (cmd_q == 8'h05) begin
               st_valid <= 1'b1;
               st_data  <= rx;
               st_index <= byte_idx[4:0];
            end
         end

         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  ss        <= 1'b0;
                  cmd_q     <= cmd;
                  tx        <= cmd;
                  pay       <= arg_bytes(cmd, arg);
                  nbytes    <= byte_total(cmd, len);
                  byte_idx  <= '0;
                  bit_cnt   <= '0;
                  cnt       <= '0;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == DIV_LAST) begin
                  cnt   <= '0;
                  sdi   <= tx[7];
                  state <= SHIFT;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            SHIFT: begin
               if (cnt != DIV_LAST) begin
                  cnt <= cnt + 16'd1;
               end else if (!sck) begin
                  cnt <= '0;
                  sck <= 1'b1;
                  rx  <= {rx[6:0], sdo};
                  if (bit_cnt == 3'd7)
                     rx_done <= 1'b1;
               end else begin
                  cnt <= '0;
                  sck <= 1'b0;
                  if (bit_cnt != 3'd7) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= {tx[6:0], 1'b0};
                     sdi     <= tx[6];
                  end else begin
                     bit_cnt  <= '0;
                     byte_idx <= byte_idx + 12'd1;
                     if (last_byte || stop_early) begin
                        sdi   <= 1'b0;
                        state <= HOLD;
                     end else if (cmd_q == 8'h02 && !byte_idx[0]) begin
                        // next payload byte is a word's high byte: fetch the word first
                        wr_req <= 1'b1;
                        state  <= WAIT_WR;
                     end else begin
                        tx  <= next_byte;
                        sdi <= next_byte[7];
                        pay <= {pay[23:0], 8'h00};
                     end
                  end
               end
            end
            WAIT_WR: begin
               if (stop_early) begin
                  sdi   <= 1'b0;
                  state <= HOLD;
               end else if (wr_valid) begin
                  tx      <= wr_data[15:8];
                  word_lo <= wr_data[7:0];
                  sdi     <= wr_data[15];
                  cnt     <= '0;
                  state   <= SHIFT;
               end
            end
            HOLD: begin
               if (cnt == DIV_LAST) begin
                  cnt   <= '0;
                  ss    <= 1'b1;
                  state <= GAP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt       <= '0;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
